// File: rtl/fetch_queue.sv
// fetch_queue: decouples fetch from decode. Each accepted PC is sent to
// instruction memory and parked in an in-order buffer until its word returns.
// Completed entries are then handed to decode in order. A flush empties the
// buffer and remembers how many responses are still owed by memory, so that
// those stale words are dropped when they arrive.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    input  logic        dec_ready,
    input  logic        flush
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] FULL_OCC = (CW + 1)'(DEPTH);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [DEPTH-1:0] done_q;

    logic [AW-1:0] alloc_ptr;
    logic [AW-1:0] resp_ptr;
    logic [AW-1:0] head_ptr;

    // used: allocated, unretired entries. pend_cnt: issued requests of the
    // live buffer still waiting for data. drop_cnt: responses owed to
    // requests that were issued before a flush.
    logic [CW-1:0] used;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] drop_cnt;

    logic [CW:0]   occ;
    logic [CW-1:0] outstanding;
    logic          credit;
    logic          issue;
    logic          retire;
    logic          resp_drop;
    logic          resp_fill;
    logic          flush_resp;

    // Credit uses registered counts only, so a retire frees a slot next cycle.
    always_comb begin
        occ         = {1'b0, used} + {1'b0, drop_cnt};
        credit      = occ < FULL_OCC;
        outstanding = drop_cnt + pend_cnt;
    end

    // Request side and handshake decode.
    always_comb begin
        imem_req_valid = fetch_valid & credit & ~flush & ~rst;
        imem_req_addr  = fetch_pc;
        fetch_ready    = credit & imem_req_ready & ~flush & ~rst;
        issue          = fetch_valid & fetch_ready;
    end

    // Response steering: stale responses are consumed first, in order.
    // A response with nothing outstanding matches neither case and is ignored.
    always_comb begin
        resp_drop  = imem_resp_valid & (drop_cnt != '0);
        resp_fill  = imem_resp_valid & (drop_cnt == '0) & (pend_cnt != '0);
        flush_resp = imem_resp_valid & (outstanding != '0);
    end

    // Decode side: head entry, outputs forced to zero while in reset.
    always_comb begin
        dec_valid = ~rst & done_q[head_ptr] & (used != '0);
        dec_pc    = rst ? 32'd0 : pc_q[head_ptr];
        dec_instr = rst ? 32'd0 : instr_q[head_ptr];
        retire    = dec_valid & dec_ready & ~flush;
    end

    // Control state: pointers, counters and done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr <= '0;
            resp_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
            done_q    <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            resp_ptr  <= '0;
            head_ptr  <= '0;
            used      <= '0;
            pend_cnt  <= '0;
            done_q    <= '0;
            drop_cnt  <= outstanding - CW'(flush_resp);
        end else begin
            // Indices never collide: issue needs a free slot, fill targets a
            // slot that is not done, retire targets a slot that is done.
            if (issue) begin
                done_q[alloc_ptr] <= 1'b0;
                alloc_ptr         <= alloc_ptr + 1'b1;
            end
            if (resp_fill) begin
                done_q[resp_ptr] <= 1'b1;
                resp_ptr         <= resp_ptr + 1'b1;
            end
            if (retire) begin
                done_q[head_ptr] <= 1'b0;
                head_ptr         <= head_ptr + 1'b1;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            used     <= used + CW'(issue) - CW'(retire);
            pend_cnt <= pend_cnt + CW'(issue) - CW'(resp_fill);
        end
    end

    // Payload storage; contents are qualified by done/used so need no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_q[alloc_ptr] <= fetch_pc;
        end
        if (resp_fill && !rst && !flush) begin
            instr_q[resp_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: drives fetch_queue with directed and randomized traffic
// against an in-order memory model and a queue-based reference of the buffer.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_ready;
    logic        flush;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .fetch_ready     (fetch_ready),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_pc          (dec_pc),
        .dec_instr       (dec_instr),
        .dec_ready       (dec_ready),
        .flush           (flush)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          done;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mreq_t;

    // Reference state: live buffer contents in order, stale response count,
    // and the memory's queue of accepted requests.
    ent_t  mq[$];
    mreq_t memq[$];
    int    drop;
    int    cyc;

    int checks;
    int failures;

    // Stimulus knobs (percentages and latency range).
    int          p_fv, p_rr, p_dr, p_rsp, p_fl, p_rst;
    int          lat_lo, lat_hi;
    int          budget;
    logic [31:0] next_pc;
    bit          use_fixed;
    logic [31:0] fixed_data;
    bit          force_flush, force_rst, rand_redirect, hold;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int unfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].done) n++;
        return n;
    endfunction

    task automatic step();
        bit          credit, exp_fr, exp_rv, exp_dv, do_issue, do_retire;
        int          out, lat;
        ent_t        e;
        logic [31:0] rnd;
        @(negedge clk);
        rst   = force_rst || ($urandom_range(99) < p_rst);
        flush = !rst && (force_flush || ($urandom_range(99) < p_fl));
        if (!hold) begin
            fetch_valid = (budget > 0) && ($urandom_range(99) < p_fv);
            fetch_pc    = fetch_valid ? next_pc : $urandom;
        end
        imem_req_ready  = $urandom_range(99) < p_rr;
        dec_ready       = $urandom_range(99) < p_dr;
        imem_resp_valid = !rst && (memq.size() > 0) && (memq[0].due <= cyc)
                          && ($urandom_range(99) < p_rsp);
        imem_resp_data  = imem_resp_valid ? memq[0].data : $urandom;
        #1;
        credit = (mq.size() + drop) < DEPTH;
        exp_fr = credit && imem_req_ready && !flush && !rst;
        exp_rv = fetch_valid && credit && !flush && !rst;
        exp_dv = !rst && (mq.size() > 0) && mq[0].done;
        check_eq("fetch_ready", 32'(fetch_ready), 32'(exp_fr));
        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check_eq("req_addr", imem_req_addr, fetch_pc);
        check_eq("dec_valid", 32'(dec_valid), 32'(exp_dv));
        if (rst) begin
            check_eq("dec_pc_rst", dec_pc, 32'd0);
            check_eq("dec_instr_rst", dec_instr, 32'd0);
        end else if (exp_dv) begin
            check_eq("dec_pc", dec_pc, mq[0].pc);
            check_eq("dec_instr", dec_instr, mq[0].instr);
        end
        do_issue  = fetch_valid && exp_fr;
        do_retire = exp_dv && dec_ready && !flush;
        assert (!(imem_resp_valid && drop == 0 && unfilled() == 0))
            else $error("response with no outstanding request at cycle %0d", cyc);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            memq.delete();
            drop = 0;
        end else if (flush) begin
            out  = drop + unfilled();
            drop = out - ((imem_resp_valid && out > 0) ? 1 : 0);
            mq.delete();
            if (imem_resp_valid) void'(memq.pop_front());
            if (rand_redirect) begin
                rnd     = $urandom;
                next_pc = rnd & 32'hFFFF_FFFC;
            end
        end else begin
            if (imem_resp_valid) begin
                void'(memq.pop_front());
                if (drop > 0) begin
                    drop--;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].done) begin
                            e       = mq[i];
                            e.done  = 1'b1;
                            e.instr = imem_resp_data;
                            mq[i]   = e;
                            break;
                        end
                    end
                end
            end
            if (do_retire) void'(mq.pop_front());
            if (do_issue) begin
                lat = $urandom_range(lat_hi, lat_lo);
                mq.push_back('{fetch_pc, 32'd0, 1'b0});
                memq.push_back('{(use_fixed ? fixed_data : $urandom), cyc + lat});
                if (budget > 0) budget--;
                next_pc = next_pc + 32'd4;
            end
        end
        hold = fetch_valid && !do_issue && !rst && !flush;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_knobs(input int fv, input int rr, input int dr, input int rsp,
                             input int lo, input int hi);
        p_fv = fv; p_rr = rr; p_dr = dr; p_rsp = rsp; lat_lo = lo; lat_hi = hi;
    endtask

    task automatic drain();
        budget = 0; hold = 1'b0;
        set_knobs(0, 100, 100, 100, 1, 1);
        run(20);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; drop = 0;
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        dec_ready = 1'b0;
        p_fl = 0; p_rst = 0; use_fixed = 1'b0; fixed_data = '0;
        force_flush = 1'b0; force_rst = 1'b0; rand_redirect = 1'b0; hold = 1'b0;
        budget = 0; next_pc = '0;
        set_knobs(0, 100, 0, 100, 1, 1);

        // Reset state.
        force_rst = 1'b1; run(2); force_rst = 1'b0;
        run(2);

        // Single fetch, latency 1, fixed word.
        use_fixed = 1'b1; fixed_data = 32'h0000_0013;
        next_pc = 32'h100; budget = 1;
        set_knobs(100, 100, 0, 100, 1, 1);
        run(4);
        use_fixed = 1'b0;
        drain();

        // Streaming 16 PCs at latency 2 with decode always ready.
        next_pc = 32'h0; budget = 16;
        set_knobs(100, 100, 100, 100, 2, 2);
        run(24);
        drain();

        // Back-pressure: fill up, free one slot, refill exactly one.
        next_pc = 32'h400; budget = 6;
        set_knobs(100, 100, 0, 100, 1, 1);
        run(8);
        p_dr = 100; run(1);
        p_dr = 0;   run(3);
        drain();

        // Flush with three requests still outstanding at latency 5.
        next_pc = 32'h800; budget = 3;
        set_knobs(100, 100, 0, 100, 5, 5);
        run(3);
        force_flush = 1'b1; run(1); force_flush = 1'b0;
        next_pc = 32'h200; budget = 1;
        set_knobs(100, 100, 100, 100, 1, 1);
        run(15);
        drain();

        // Flush, response and retire handshake all in the same cycle.
        next_pc = 32'hC00; budget = 3;
        set_knobs(100, 100, 0, 100, 1, 1);
        run(3);
        budget = 0; p_dr = 100; force_flush = 1'b1; run(1); force_flush = 1'b0;
        run(3);
        drain();

        // Reset mid-stream with two entries complete.
        next_pc = 32'hE00; budget = 3;
        set_knobs(100, 100, 0, 100, 1, 1);
        run(3);
        force_rst = 1'b1; run(1); force_rst = 1'b0;
        hold = 1'b0;
        next_pc = 32'h0; budget = 1;
        set_knobs(100, 100, 100, 100, 1, 1);
        run(6);
        drain();

        // Randomized traffic with flushes, resets and variable latency.
        rand_redirect = 1'b1;
        for (int s = 0; s < 40; s++) begin
            budget = 100000;
            p_fl   = $urandom_range(5);
            p_rst  = $urandom_range(1);
            lat_lo = $urandom_range(3, 1);
            set_knobs($urandom_range(100, 30), $urandom_range(100, 30),
                      $urandom_range(100, 20), $urandom_range(100, 40),
                      lat_lo, lat_lo + $urandom_range(3));
            run(75);
        end
        p_fl = 0; p_rst = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
